// File: rtl/hwpe_stream_package.sv
// Shared types for the strided stream sink: FSM state, latched job fields
// and the status flags presented to the controlling engine.
package hwpe_stream_package;

  localparam int SINK_LEN_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WORKING = 2'd1,
    DONE    = 2'd2
  } state_sink_strided_t;

  typedef struct packed {
    logic [31:0]               base_addr;
    logic [SINK_LEN_WIDTH-1:0] trans_size;
    logic [SINK_LEN_WIDTH-1:0] line_length;
    logic [31:0]               line_stride;
  } ctrl_sink_strided_t;

  typedef struct packed {
    logic                      ready_start;
    logic                      busy;
    logic                      done;
    logic [SINK_LEN_WIDTH-1:0] beat_cnt;
  } flags_sink_strided_t;

endpackage

// File: rtl/hwpe_stream_addressgen_2d.sv
// 2D address generator: tracks word/line position as running byte offsets
// so the beat address needs only adders, never a multiplier.
module hwpe_stream_addressgen_2d #(
  parameter int          LEN_WIDTH  = 16,
  parameter logic [31:0] BEAT_BYTES = 32'd16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_clear,
  input  logic                 i_load,
  input  logic                 i_enable,
  input  logic [31:0]          i_base_addr,
  input  logic [31:0]          i_line_stride,
  input  logic [LEN_WIDTH-1:0] i_line_length,
  output logic [31:0]          o_addr
);

  logic [LEN_WIDTH-1:0] r_word_idx;
  logic [31:0]          r_line_off;
  logic [31:0]          r_word_off;
  logic                 w_line_end;

  assign w_line_end = (r_word_idx == i_line_length - LEN_WIDTH'(1));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clear || i_load) begin
      r_word_idx <= '0;
      r_line_off <= '0;
      r_word_off <= '0;
    end else if (i_enable) begin
      if (w_line_end) begin
        r_word_idx <= '0;
        r_word_off <= '0;
        r_line_off <= r_line_off + i_line_stride;
      end else begin
        r_word_idx <= r_word_idx + LEN_WIDTH'(1);
        r_word_off <= r_word_off + BEAT_BYTES;
      end
    end
  end

  assign o_addr = i_base_addr + r_line_off + r_word_off;

endmodule

// File: rtl/hwpe_stream_sink_strided.sv
// Strided stream sink: spreads each DATA_WIDTH beat over NB_TCDM_PORTS
// 32-bit TCDM write ports; each port is retired independently within a beat.
module hwpe_stream_sink_strided
  import hwpe_stream_package::*;
#(
  parameter int DATA_WIDTH    = 128,
  parameter int NB_TCDM_PORTS = DATA_WIDTH / 32,
  parameter int LEN_WIDTH     = SINK_LEN_WIDTH
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        clear_i,
  input  logic                        start_i,
  input  logic [31:0]                 base_addr_i,
  input  logic [LEN_WIDTH-1:0]        trans_size_i,
  input  logic [LEN_WIDTH-1:0]        line_length_i,
  input  logic [31:0]                 line_stride_i,
  input  logic [DATA_WIDTH-1:0]       stream_data_i,
  input  logic [DATA_WIDTH/8-1:0]     stream_strb_i,
  input  logic                        stream_valid_i,
  output logic                        stream_ready_o,
  output logic [NB_TCDM_PORTS-1:0]    tcdm_req_o,
  input  logic [NB_TCDM_PORTS-1:0]    tcdm_gnt_i,
  output logic [32*NB_TCDM_PORTS-1:0] tcdm_add_o,
  output logic [NB_TCDM_PORTS-1:0]    tcdm_wen_o,
  output logic [4*NB_TCDM_PORTS-1:0]  tcdm_be_o,
  output logic [32*NB_TCDM_PORTS-1:0] tcdm_data_o,
  output logic                        ready_start_o,
  output logic                        busy_o,
  output logic                        done_o,
  output logic [LEN_WIDTH-1:0]        beat_cnt_o,
  output logic [1:0]                  dbg_state_o
);

  localparam logic [31:0] BEAT_BYTES = 32'(4 * NB_TCDM_PORTS);

  state_sink_strided_t r_state, w_state_next;
  ctrl_sink_strided_t  r_ctrl;
  flags_sink_strided_t w_flags;

  logic [LEN_WIDTH-1:0]     r_beat_cnt;
  logic [NB_TCDM_PORTS-1:0] r_granted;
  logic [NB_TCDM_PORTS-1:0] w_req;
  logic [NB_TCDM_PORTS-1:0] w_served;
  logic                     w_start;
  logic                     w_busy;
  logic                     w_beat_done;
  logic                     w_last_beat;
  logic [31:0]              w_beat_addr;

  // Stream handshake: a beat is consumed (stream_ready_o=1) only in the cycle
  // where every port is either already granted or granted right now; upstream
  // keeps data/strb/valid stable until then. req depends only on registered
  // grant state, so there is no gnt->req loop on any port.
  assign w_start     = (r_state == IDLE) && start_i;
  assign w_busy      = (r_state == WORKING);
  assign w_req       = {NB_TCDM_PORTS{w_busy && stream_valid_i}} & ~r_granted;
  assign w_served    = r_granted | (w_req & tcdm_gnt_i);
  assign w_beat_done = w_busy && stream_valid_i && (&w_served);
  assign w_last_beat = (r_beat_cnt == r_ctrl.trans_size - LEN_WIDTH'(1));

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (start_i) begin
          w_state_next = (trans_size_i == '0) ? DONE : WORKING;
        end
      end
      WORKING: begin
        if (w_beat_done && w_last_beat) begin
          w_state_next = DONE;
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_flags             = '0;
    w_flags.ready_start = (r_state == IDLE);
    w_flags.busy        = (r_state == WORKING);
    w_flags.done        = (r_state == DONE);
    w_flags.beat_cnt    = r_beat_cnt;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      r_ctrl     <= '0;
      r_beat_cnt <= '0;
      r_granted  <= '0;
    end else begin
      if (w_start) begin
        r_ctrl.base_addr   <= base_addr_i;
        r_ctrl.trans_size  <= trans_size_i;
        // A zero line length means the whole job is a single line.
        r_ctrl.line_length <= (line_length_i == '0) ? trans_size_i : line_length_i;
        r_ctrl.line_stride <= line_stride_i;
        r_beat_cnt         <= '0;
      end
      if (w_beat_done) begin
        r_beat_cnt <= r_beat_cnt + LEN_WIDTH'(1);
        r_granted  <= '0;
      end else if (w_busy) begin
        r_granted <= r_granted | (w_req & tcdm_gnt_i);
      end
    end
  end

  hwpe_stream_addressgen_2d #(
    .LEN_WIDTH  (LEN_WIDTH),
    .BEAT_BYTES (BEAT_BYTES)
  ) i_addressgen (
    .i_clk         (clk_i),
    .i_rst_n       (rst_ni),
    .i_clear       (clear_i),
    .i_load        (w_start),
    .i_enable      (w_beat_done),
    .i_base_addr   (r_ctrl.base_addr),
    .i_line_stride (r_ctrl.line_stride),
    .i_line_length (r_ctrl.line_length),
    .o_addr        (w_beat_addr)
  );

  always_comb begin
    tcdm_req_o  = w_req;
    tcdm_wen_o  = '0;
    tcdm_add_o  = '0;
    tcdm_be_o   = '0;
    tcdm_data_o = '0;
    for (int i = 0; i < NB_TCDM_PORTS; i++) begin
      if (w_busy) begin
        tcdm_add_o[32*i +: 32]  = w_beat_addr + 32'(4 * i);
        tcdm_be_o[4*i +: 4]     = stream_strb_i[4*i +: 4];
        tcdm_data_o[32*i +: 32] = stream_data_i[32*i +: 32];
      end
    end
  end

  assign stream_ready_o = w_beat_done;
  assign ready_start_o  = w_flags.ready_start;
  assign busy_o         = w_flags.busy;
  assign done_o         = w_flags.done;
  assign beat_cnt_o     = w_flags.beat_cnt;
  assign dbg_state_o    = r_state;

endmodule

// File: tb/tb_hwpe_stream_sink_strided.sv
// Bench for the strided stream sink: directed job sequence with randomized
// data, strobes and grants, checked against an address/handshake model.
module tb_hwpe_stream_sink_strided;

  localparam int DW = 128;
  localparam int NP = 4;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          clear_i;
  logic          start_i;
  logic [31:0]   base_addr_i;
  logic [15:0]   trans_size_i;
  logic [15:0]   line_length_i;
  logic [31:0]   line_stride_i;
  logic [DW-1:0] stream_data_i;
  logic [15:0]   stream_strb_i;
  logic          stream_valid_i;
  logic          stream_ready_o;
  logic [NP-1:0] tcdm_req_o;
  logic [NP-1:0] tcdm_gnt_i;
  logic [127:0]  tcdm_add_o;
  logic [NP-1:0] tcdm_wen_o;
  logic [15:0]   tcdm_be_o;
  logic [127:0]  tcdm_data_o;
  logic          ready_start_o;
  logic          busy_o;
  logic          done_o;
  logic [15:0]   beat_cnt_o;
  logic [1:0]    dbg_state_o;

  int n_checks = 0;
  int n_fail   = 0;
  int m_trans  = 0;
  logic [31:0] exp_q[$];

  always #5 clk_i = ~clk_i;

  hwpe_stream_sink_strided #(
    .DATA_WIDTH (DW)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .clear_i        (clear_i),
    .start_i        (start_i),
    .base_addr_i    (base_addr_i),
    .trans_size_i   (trans_size_i),
    .line_length_i  (line_length_i),
    .line_stride_i  (line_stride_i),
    .stream_data_i  (stream_data_i),
    .stream_strb_i  (stream_strb_i),
    .stream_valid_i (stream_valid_i),
    .stream_ready_o (stream_ready_o),
    .tcdm_req_o     (tcdm_req_o),
    .tcdm_gnt_i     (tcdm_gnt_i),
    .tcdm_add_o     (tcdm_add_o),
    .tcdm_wen_o     (tcdm_wen_o),
    .tcdm_be_o      (tcdm_be_o),
    .tcdm_data_o    (tcdm_data_o),
    .ready_start_o  (ready_start_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .beat_cnt_o     (beat_cnt_o),
    .dbg_state_o    (dbg_state_o)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"}, tcdm_req_o, 0);
    chk({tag, "_ready"}, stream_ready_o, 0);
    chk({tag, "_ready_start"}, ready_start_o, 1);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_done"}, done_o, 0);
    chk({tag, "_beat_cnt"}, beat_cnt_o, 0);
    chk({tag, "_add"}, tcdm_add_o, 0);
    chk({tag, "_be"}, tcdm_be_o, 0);
    chk({tag, "_data"}, tcdm_data_o, 0);
  endtask

  // Expected beat addresses come straight from the 2D rule:
  // base + (k / line_len) * stride + (k % line_len) * beat_bytes.
  task automatic start_job(input logic [31:0] b, input int t, input int l, input logic [31:0] s);
    int eff;
    eff = (l == 0) ? t : l;
    exp_q.delete();
    for (int k = 0; k < t; k++) begin
      exp_q.push_back(b + 32'(k / eff) * s + 32'((k % eff) * 16));
    end
    m_trans = t;
    @(negedge clk_i);
    start_i = 1'b1; base_addr_i = b; trans_size_i = 16'(t);
    line_length_i = 16'(l); line_stride_i = s; stream_valid_i = 1'b0;
    #1;
    chk("start_ready_start", ready_start_o, 1);
    @(negedge clk_i);
    start_i = 1'b0;
    #1;
    chk("start_busy", busy_o, (t != 0));
    chk("start_done", done_o, (t == 0));
    chk("start_beat_cnt", beat_cnt_o, 0);
    chk("start_req", tcdm_req_o, 0);
    if (t == 0) begin
      @(negedge clk_i);
      #1;
      chk("zero_done_gone", done_o, 0);
      chk("zero_ready_start", ready_start_o, 1);
      chk("zero_req", tcdm_req_o, 0);
    end
  endtask

  task automatic do_beat(input int k, input int mode);
    logic [31:0]  a;
    logic [127:0] add_e;
    logic [127:0] d;
    logic [15:0]  s;
    logic [3:0]   served, req_e, g;
    logic [3:0]   stag[4];
    int cyc;
    bit fin;
    stag[0] = 4'b0001; stag[1] = 4'b0100; stag[2] = 4'b0000; stag[3] = 4'b1010;
    a = exp_q.pop_front();
    for (int i = 0; i < NP; i++) add_e[32*i +: 32] = a + 32'(4 * i);
    if (mode == 1 && $urandom_range(0, 2) == 0) begin
      @(negedge clk_i);
      stream_valid_i = 1'b0;
      tcdm_gnt_i = 4'($urandom);
      #1;
      chk("bubble_req", tcdm_req_o, 0);
      chk("bubble_ready", stream_ready_o, 0);
    end
    @(negedge clk_i);
    d = {$urandom, $urandom, $urandom, $urandom};
    s = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
    stream_data_i = d; stream_strb_i = s; stream_valid_i = 1'b1;
    served = '0; cyc = 0; fin = 1'b0;
    while (!fin && cyc < 64) begin
      if (cyc > 0) @(negedge clk_i);
      case (mode)
        0:       g = 4'hF;
        2:       g = (cyc < 4) ? stag[cyc] : 4'hF;
        default: g = 4'($urandom);
      endcase
      tcdm_gnt_i = g;
      #1;
      req_e = ~served;
      chk("beat_req", tcdm_req_o, req_e);
      chk("beat_ready", stream_ready_o, &(served | (req_e & g)));
      chk("beat_add", tcdm_add_o, add_e);
      chk("beat_data", tcdm_data_o, d);
      chk("beat_be", tcdm_be_o, s);
      chk("beat_wen", tcdm_wen_o, 0);
      chk("beat_cnt", beat_cnt_o, 16'(k));
      chk("beat_busy", busy_o, 1);
      served = served | (req_e & g);
      fin = &served;
      cyc++;
    end
    chk("beat_complete_in_budget", fin, 1);
    if (mode == 2) chk("stag_cycles", 128'(cyc), 4);
  endtask

  task automatic finish_job();
    @(negedge clk_i);
    stream_valid_i = 1'b0; tcdm_gnt_i = '0;
    #1;
    chk("end_done", done_o, 1);
    chk("end_beat_cnt", beat_cnt_o, 16'(m_trans));
    chk("end_busy", busy_o, 0);
    chk("end_req", tcdm_req_o, 0);
    @(negedge clk_i);
    #1;
    chk("end_done_pulse", done_o, 0);
    chk("end_ready_start", ready_start_o, 1);
    chk("end_add", tcdm_add_o, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rb, rs;
    int rt, rl;
    rst_ni = 1'b0; clear_i = 1'b0; start_i = 1'b1;
    base_addr_i = 32'h0; trans_size_i = 16'd3; line_length_i = '0; line_stride_i = '0;
    stream_data_i = '0; stream_strb_i = '0; stream_valid_i = 1'b0; tcdm_gnt_i = '0;
    repeat (2) @(negedge clk_i);
    #1;
    chk_reset_outputs("reset");
    rst_ni = 1'b1; start_i = 1'b0;

    // single beat, all grants immediate
    start_job(32'h1000, 1, 0, 32'h0);
    do_beat(0, 0);
    finish_job();

    // staggered grants within one beat
    start_job(32'h1000, 1, 0, 32'h0);
    do_beat(0, 2);
    finish_job();

    // 2D stride with random grants
    start_job(32'h2000, 6, 3, 32'h100);
    for (int k = 0; k < 6; k++) do_beat(k, 1);
    finish_job();

    // random jobs, including address wrap-around
    repeat (6) begin
      rt = $urandom_range(1, 9);
      rl = $urandom_range(0, 4);
      rb = $urandom & 32'hFFFF_FFFC;
      rs = $urandom & 32'hFFFF_FFFC;
      start_job(rb, rt, rl, rs);
      for (int k = 0; k < rt; k++) do_beat(k, 1);
      finish_job();
    end

    // empty job
    start_job(32'h4000, 0, 2, 32'h40);

    // clear mid-beat with port1 already granted
    start_job(32'h3000, 8, 0, 32'h0);
    for (int k = 0; k < 3; k++) do_beat(k, 0);
    @(negedge clk_i);
    stream_data_i = {$urandom, $urandom, $urandom, $urandom};
    stream_strb_i = 16'hFFFF; stream_valid_i = 1'b1; tcdm_gnt_i = 4'b0010;
    #1;
    chk("clr_req_before", tcdm_req_o, 4'b1111);
    @(negedge clk_i);
    tcdm_gnt_i = '0; clear_i = 1'b1;
    #1;
    chk("clr_req_partial", tcdm_req_o, 4'b1101);
    @(negedge clk_i);
    clear_i = 1'b0;
    #1;
    chk("clr_req", tcdm_req_o, 0);
    chk("clr_beat_cnt", beat_cnt_o, 0);
    chk("clr_ready_start", ready_start_o, 1);
    chk("clr_done", done_o, 0);
    chk("clr_ready", stream_ready_o, 0);
    stream_valid_i = 1'b0;
    @(negedge clk_i);
    #1;
    chk("clr_no_done", done_o, 0);
    start_job(32'h6000, 4, 2, 32'h80);
    for (int k = 0; k < 4; k++) do_beat(k, 1);
    finish_job();

    // reset while working, with start_i asserted in the reset cycle
    start_job(32'h5000, 4, 0, 32'h0);
    do_beat(0, 0);
    @(negedge clk_i);
    stream_valid_i = 1'b1; tcdm_gnt_i = '0; rst_ni = 1'b0; start_i = 1'b1;
    @(negedge clk_i);
    #1;
    chk_reset_outputs("wreset");
    rst_ni = 1'b1; start_i = 1'b0; stream_valid_i = 1'b0;
    @(negedge clk_i);
    #1;
    chk("wreset_ignored_start", ready_start_o, 1);
    chk("wreset_busy", busy_o, 0);

    start_job(32'hA000, 5, 2, 32'h40);
    for (int k = 0; k < 5; k++) do_beat(k, 1);
    finish_job();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
